// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IF/DM busywait ports and downstream memory port of mem_port_arbiter
//
// Purpose: groups the three buses the arbiter sits between.
//   IF port : IF_READ, IF_ADDR in; IF_RDATA, IF_BUSYWAIT out (arbiter view)
//   DM port : DM_READ, DM_WRITE, DM_ADDR, DM_WDATA, DM_BE in; DM_RDATA, DM_BUSYWAIT out
//   MEM port: MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA, MEM_BE out; MEM_RDATA, MEM_READY in
// Modports: slave = arbiter view, master = pipeline + memory view.
interface mem_port_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic                  IF_READ;
   logic [ADDR_WIDTH-1:0] IF_ADDR;
   logic [DATA_WIDTH-1:0] IF_RDATA;
   logic                  IF_BUSYWAIT;

   logic                  DM_READ;
   logic                  DM_WRITE;
   logic [ADDR_WIDTH-1:0] DM_ADDR;
   logic [DATA_WIDTH-1:0] DM_WDATA;
   logic [BE_WIDTH-1:0]   DM_BE;
   logic [DATA_WIDTH-1:0] DM_RDATA;
   logic                  DM_BUSYWAIT;

   logic                  MEM_READ;
   logic                  MEM_WRITE;
   logic [ADDR_WIDTH-1:0] MEM_ADDR;
   logic [DATA_WIDTH-1:0] MEM_WDATA;
   logic [BE_WIDTH-1:0]   MEM_BE;
   logic [DATA_WIDTH-1:0] MEM_RDATA;
   logic                  MEM_READY;

   modport slave (
      input  IF_READ, IF_ADDR,
      output IF_RDATA, IF_BUSYWAIT,
      input  DM_READ, DM_WRITE, DM_ADDR, DM_WDATA, DM_BE,
      output DM_RDATA, DM_BUSYWAIT,
      output MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA, MEM_BE,
      input  MEM_RDATA, MEM_READY
   );

   modport master (
      output IF_READ, IF_ADDR,
      input  IF_RDATA, IF_BUSYWAIT,
      output DM_READ, DM_WRITE, DM_ADDR, DM_WDATA, DM_BE,
      input  DM_RDATA, DM_BUSYWAIT,
      input  MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA, MEM_BE,
      output MEM_RDATA, MEM_READY
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between the IF and DM busywait ports
//
// Purpose: grants one memory access at a time (IDLE / IF_ACC / DM_ACC). DM wins
// ties unless IF has already lost STARVE_LIMIT grants in a row while waiting.
// Ports:
//   CLK   in  rising-edge clock
//   RESET in  asynchronous active-low reset
//   bus   slave modport of mem_port_arbiter_if (IF port, DM port, MEM port)
module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   mem_port_arbiter_if.slave bus
);
   localparam int BE_WIDTH  = DATA_WIDTH / 8;
   localparam int CNT_WIDTH = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_WIDTH-1:0] STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IF_ACC = 2'd1,
      DM_ACC = 2'd2
   } state_t;

   state_t                state_q;
   logic [CNT_WIDTH-1:0]  starve_cnt_q;
   logic [CNT_WIDTH-1:0]  starve_cnt_d;
   logic                  mem_read_q;
   logic                  mem_write_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic [BE_WIDTH-1:0]   mem_be_q;
   logic [DATA_WIDTH-1:0] if_rdata_q;
   logic [DATA_WIDTH-1:0] dm_rdata_q;

   logic dm_req;
   logic if_starved;
   logic grant_dm;
   logic grant_if;
   logic if_done;
   logic dm_done;

   assign dm_req     = bus.DM_READ | bus.DM_WRITE;
   assign if_starved = bus.IF_READ && (starve_cnt_q >= STARVE_MAX);
   assign grant_dm   = (state_q == IDLE) && dm_req && !if_starved;
   assign grant_if   = (state_q == IDLE) && bus.IF_READ && !grant_dm;
   assign if_done    = (state_q == IF_ACC) && bus.MEM_READY;
   assign dm_done    = (state_q == DM_ACC) && bus.MEM_READY;

   // Counts DM wins that left a waiting fetch behind; any IF win, or a DM win
   // with no fetch pending, means IF was not starved and the count restarts.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (grant_if) begin
         starve_cnt_d = '0;
      end else if (grant_dm) begin
         if (!bus.IF_READ) begin
            starve_cnt_d = '0;
         end else if (starve_cnt_q < STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_be_q     <= '0;
         if_rdata_q   <= '0;
         dm_rdata_q   <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         case (state_q)
            IDLE: begin
               // MEM_READY is ignored here: a late pulse from an abandoned
               // access must not complete anything.
               if (grant_dm) begin
                  state_q    <= DM_ACC;
                  mem_addr_q <= bus.DM_ADDR;
                  // Read and write together is treated as a write.
                  if (bus.DM_WRITE) begin
                     mem_write_q <= 1'b1;
                     mem_wdata_q <= bus.DM_WDATA;
                     mem_be_q    <= bus.DM_BE;
                  end else begin
                     mem_read_q  <= 1'b1;
                     mem_wdata_q <= '0;
                     mem_be_q    <= '1;
                  end
               end else if (grant_if) begin
                  state_q     <= IF_ACC;
                  mem_read_q  <= 1'b1;
                  mem_addr_q  <= bus.IF_ADDR;
                  mem_wdata_q <= '0;
                  mem_be_q    <= '1;
               end
            end
            IF_ACC: begin
               if (bus.MEM_READY) begin
                  state_q    <= IDLE;
                  mem_read_q <= 1'b0;
                  // A fetch dropped mid-access discards its result.
                  if (bus.IF_READ) begin
                     if_rdata_q <= bus.MEM_RDATA;
                  end
               end
            end
            DM_ACC: begin
               if (bus.MEM_READY) begin
                  state_q     <= IDLE;
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  // Only a still-pending load captures data; stores return none.
                  if (mem_read_q && bus.DM_READ) begin
                     dm_rdata_q <= bus.MEM_RDATA;
                  end
               end
            end
            default: begin
               state_q     <= IDLE;
               mem_read_q  <= 1'b0;
               mem_write_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.MEM_READ  = mem_read_q;
   assign bus.MEM_WRITE = mem_write_q;
   assign bus.MEM_ADDR  = mem_addr_q;
   assign bus.MEM_WDATA = mem_wdata_q;
   assign bus.MEM_BE    = mem_be_q;

   // Completion data is passed straight through so the pipeline can use it in
   // the same cycle its busywait drops; otherwise the last captured word holds.
   assign bus.IF_RDATA    = if_done ? bus.MEM_RDATA : if_rdata_q;
   assign bus.DM_RDATA    = dm_done ? bus.MEM_RDATA : dm_rdata_q;
   assign bus.IF_BUSYWAIT = bus.IF_READ & ~if_done;
   assign bus.DM_BUSYWAIT = dm_req & ~dm_done;
endmodule
